itch_msg_decoder: RTL

- Sits directly downstream of the Ethernet/IP/UDP parser and consumes its UDP payload byte stream: a MoldUDP64 header followed by length-prefixed ITCH messages.
- Walks the MoldUDP64 framing, counts messages and decodes Add Order ('A'), Delete Order ('D') and Order Executed ('E') into registered field outputs with a one-cycle valid pulse.
- Its outputs feed the order book stage.

---
 rtl/itch_msg_decoder_pkg.sv | 67 ++++++
 rtl/itch_field_extract.sv | 73 +++++++
 rtl/itch_msg_decoder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/itch_msg_decoder_pkg.sv
// Shared types and constants for the MoldUDP64 / ITCH message decoder.
// Message layouts are packed MSB-first, so the type byte is the top field.
package itch_msg_decoder_pkg;

  localparam logic [7:0] ITCH_ADD  = 8'h41;
  localparam logic [7:0] ITCH_DEL  = 8'h44;
  localparam logic [7:0] ITCH_EXEC = 8'h45;

  localparam int ITCH_ADD_LEN  = 36;
  localparam int ITCH_DEL_LEN  = 19;
  localparam int ITCH_EXEC_LEN = 31;
  localparam int MOLD_HDR_LEN  = 20;

  typedef enum logic [1:0] {
    IDLE,
    MOLD_HDR,
    MSG_LEN,
    MSG_BODY
  } moldStateType;

  typedef struct packed {
    logic [7:0]  msgType;
    logic [15:0] locate;
    logic [15:0] trackNum;
    logic [47:0] timeStamp;
    logic [63:0] refNum;
    logic [7:0]  buySell;
    logic [31:0] shares;
    logic [63:0] stock;
    logic [31:0] price;
  } itchAddOrderType;

  typedef struct packed {
    logic [7:0]  msgType;
    logic [15:0] locate;
    logic [15:0] trackNum;
    logic [47:0] timeStamp;
    logic [63:0] refNum;
  } itchDeleteOrderType;

  typedef struct packed {
    logic [7:0]  msgType;
    logic [15:0] locate;
    logic [15:0] trackNum;
    logic [47:0] timeStamp;
    logic [63:0] refNum;
    logic [31:0] execShares;
    logic [63:0] matchNum;
  } itchOrderExecutedType;

  typedef struct packed {
    logic [79:0] session;
    logic [63:0] seqNum;
    logic [15:0] msgCount;
  } moldHeaderType;

  // Zero means "not a type this block decodes".
  function automatic logic [15:0] itchExpectedLen(input logic [7:0] msgType);
    case (msgType)
      ITCH_ADD:  return 16'(ITCH_ADD_LEN);
      ITCH_DEL:  return 16'(ITCH_DEL_LEN);
      ITCH_EXEC: return 16'(ITCH_EXEC_LEN);
      default:   return 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/itch_field_extract.sv
// Combinational field slicer: the newest byte sits in the capture LSB, so a
// message of length L occupies the low L bytes with its type byte on top.
module itch_field_extract
  import itch_msg_decoder_pkg::*;
#(
  parameter int MAX_MSG_BYTES = 36
) (
  input  logic [MAX_MSG_BYTES*8-1:0] capture,
  input  logic [7:0]                 msgType,
  output logic [7:0]                 fieldType,
  output logic [15:0]                locate,
  output logic [15:0]                trackNum,
  output logic [47:0]                timeStamp,
  output logic [63:0]                refNum,
  output logic [7:0]                 buySell,
  output logic [31:0]                shares,
  output logic [63:0]                stock,
  output logic [31:0]                price,
  output logic [63:0]                matchNum
);

  itchAddOrderType      addMsg;
  itchDeleteOrderType   delMsg;
  itchOrderExecutedType execMsg;

  assign addMsg  = capture[ITCH_ADD_LEN*8-1:0];
  assign delMsg  = capture[ITCH_DEL_LEN*8-1:0];
  assign execMsg = capture[ITCH_EXEC_LEN*8-1:0];

  always_comb begin
    fieldType = '0;
    locate    = '0;
    trackNum  = '0;
    timeStamp = '0;
    refNum    = '0;
    buySell   = '0;
    shares    = '0;
    stock     = '0;
    price     = '0;
    matchNum  = '0;
    case (msgType)
      ITCH_ADD: begin
        fieldType = addMsg.msgType;
        locate    = addMsg.locate;
        trackNum  = addMsg.trackNum;
        timeStamp = addMsg.timeStamp;
        refNum    = addMsg.refNum;
        buySell   = addMsg.buySell;
        shares    = addMsg.shares;
        stock     = addMsg.stock;
        price     = addMsg.price;
      end
      ITCH_DEL: begin
        fieldType = delMsg.msgType;
        locate    = delMsg.locate;
        trackNum  = delMsg.trackNum;
        timeStamp = delMsg.timeStamp;
        refNum    = delMsg.refNum;
      end
      ITCH_EXEC: begin
        fieldType = execMsg.msgType;
        locate    = execMsg.locate;
        trackNum  = execMsg.trackNum;
        timeStamp = execMsg.timeStamp;
        refNum    = execMsg.refNum;
        shares    = execMsg.execShares;
        matchNum  = execMsg.matchNum;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/itch_msg_decoder.sv
// Walks MoldUDP64 framing on the UDP payload stream and decodes ITCH Add,
// Delete and Executed messages into registered fields with a one-cycle pulse.
module itch_msg_decoder
  import itch_msg_decoder_pkg::*;
#(
  parameter int MAX_MSG_BYTES = 36,
  parameter int LEN_W         = 16
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         dataValid,
  input  logic [7:0]   data,
  input  logic         sof,
  output logic         msgValid,
  output logic [7:0]   msgType,
  output logic [15:0]  locate,
  output logic [15:0]  trackNum,
  output logic [47:0]  timeStamp,
  output logic [63:0]  refNum,
  output logic [7:0]   buySell,
  output logic [31:0]  shares,
  output logic [63:0]  stock,
  output logic [31:0]  price,
  output logic [63:0]  matchNum,
  output logic [63:0]  seqNum,
  output logic         lenErr,
  output logic         truncErr,
  output moldStateType dbgState
);

  // Stream contract: a byte is consumed on every clock where dataValid=1;
  // there is no ready, so every state accepts a byte per cycle without stall.

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  moldStateType               state;
  logic [4:0]                 hdrCnt;
  logic                       lenPhase;
  logic [7:0]                 lenHi;
  logic [LEN_W-1:0]           msgRemain;
  logic [LEN_W-1:0]           bodyRemain;
  logic [LEN_W-1:0]           bodyLen;
  logic [LEN_W-1:0]           bodyCnt;
  logic [LEN_W-1:0]           msgIdx;
  logic [63:0]                seqBase;
  logic [MAX_MSG_BYTES*8-1:0] capture;
  logic [7:0]                 typeReg;

  logic                       firstBody;
  logic [7:0]                 curType;
  logic [LEN_W-1:0]           expLen;
  logic                       knownType;
  logic [LEN_W-1:0]           remainDec;
  logic [LEN_W-1:0]           lenNew;
  logic [LEN_W-1:0]           hdrCount;
  logic [MAX_MSG_BYTES*8-1:0] capNext;

  logic [7:0]  xType;
  logic [15:0] xLocate;
  logic [15:0] xTrack;
  logic [47:0] xTime;
  logic [63:0] xRef;
  logic [7:0]  xBuySell;
  logic [31:0] xShares;
  logic [63:0] xStock;
  logic [31:0] xPrice;
  logic [63:0] xMatch;

  assign dbgState = state;

  // The last body byte is still on the input bus, so extraction works on the
  // capture value it is about to become.
  always_comb begin
    firstBody = (bodyCnt == '0);
    curType   = firstBody ? data : typeReg;
    expLen    = LEN_W'(itchExpectedLen(curType));
    knownType = (expLen != '0);
    remainDec = (msgRemain != '0) ? msgRemain - ONE : '0;
    lenNew    = LEN_W'({lenHi, data});
    hdrCount  = LEN_W'({msgRemain[7:0], data});
    capNext   = (bodyCnt < LEN_W'(MAX_MSG_BYTES)) ?
                {capture[MAX_MSG_BYTES*8-9:0], data} : capture;
  end

  itch_field_extract #(.MAX_MSG_BYTES(MAX_MSG_BYTES)) u_extract (
    .capture   (capNext),
    .msgType   (curType),
    .fieldType (xType),
    .locate    (xLocate),
    .trackNum  (xTrack),
    .timeStamp (xTime),
    .refNum    (xRef),
    .buySell   (xBuySell),
    .shares    (xShares),
    .stock     (xStock),
    .price     (xPrice),
    .matchNum  (xMatch)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= IDLE;
      hdrCnt     <= '0;
      lenPhase   <= 1'b0;
      lenHi      <= '0;
      msgRemain  <= '0;
      bodyRemain <= '0;
      bodyLen    <= '0;
      bodyCnt    <= '0;
      msgIdx     <= '0;
      seqBase    <= '0;
      capture    <= '0;
      typeReg    <= '0;
      msgValid   <= 1'b0;
      msgType    <= '0;
      locate     <= '0;
      trackNum   <= '0;
      timeStamp  <= '0;
      refNum     <= '0;
      buySell    <= '0;
      shares     <= '0;
      stock      <= '0;
      price      <= '0;
      matchNum   <= '0;
      seqNum     <= '0;
      lenErr     <= 1'b0;
      truncErr   <= 1'b0;
    end else begin
      msgValid <= 1'b0;
      lenErr   <= 1'b0;
      truncErr <= 1'b0;
      if (dataValid) begin
        if (sof) begin
          // A new frame always wins; whatever was open is abandoned.
          if (state != IDLE) truncErr <= 1'b1;
          state    <= MOLD_HDR;
          hdrCnt   <= 5'd1;
          msgIdx   <= '0;
          lenPhase <= 1'b0;
          bodyCnt  <= '0;
        end else begin
          case (state)
            IDLE: ;
            MOLD_HDR: begin
              hdrCnt <= hdrCnt + 5'd1;
              if (hdrCnt >= 5'd10 && hdrCnt <= 5'd17) seqBase <= {seqBase[55:0], data};
              if (hdrCnt == 5'd18) msgRemain <= LEN_W'(data);
              if (hdrCnt == 5'(MOLD_HDR_LEN - 1)) begin
                msgRemain <= hdrCount;
                lenPhase  <= 1'b0;
                state     <= (hdrCount == '0 || hdrCount == '1) ? IDLE : MSG_LEN;
              end
            end
            MSG_LEN: begin
              if (!lenPhase) begin
                lenHi    <= data;
                lenPhase <= 1'b1;
              end else begin
                lenPhase <= 1'b0;
                if (lenNew == '0) begin
                  msgRemain <= remainDec;
                  if (remainDec == '0) state <= IDLE;
                end else begin
                  bodyLen    <= lenNew;
                  bodyRemain <= lenNew;
                  bodyCnt    <= '0;
                  state      <= MSG_BODY;
                end
              end
            end
            MSG_BODY: begin
              capture    <= capNext;
              bodyRemain <= bodyRemain - ONE;
              bodyCnt    <= bodyCnt + ONE;
              if (firstBody) typeReg <= data;
              if (bodyRemain == ONE) begin
                if (knownType && bodyLen == expLen) begin
                  msgValid  <= 1'b1;
                  msgType   <= xType;
                  locate    <= xLocate;
                  trackNum  <= xTrack;
                  timeStamp <= xTime;
                  refNum    <= xRef;
                  buySell   <= xBuySell;
                  shares    <= xShares;
                  stock     <= xStock;
                  price     <= xPrice;
                  matchNum  <= xMatch;
                  seqNum    <= seqBase + 64'(msgIdx);
                end else if (knownType) begin
                  lenErr <= 1'b1;
                end
                msgIdx    <= msgIdx + ONE;
                msgRemain <= remainDec;
                bodyCnt   <= '0;
                lenPhase  <= 1'b0;
                state     <= (remainDec == '0) ? IDLE : MSG_LEN;
              end
            end
          endcase
        end
      end
    end
  end

endmodule
